ddr3_read_master: RTL and testbench

DDR3_READ_MASTER -- requirements
Module: ddr3_read_master

---
 rtl/ddr3_read_master.sv | 139 +++++++++++++
 tb/tb_ddr3_read_master.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_read_master.sv
// ddr3_read_master: DDR3 readback master with a bounded number of
// outstanding reads, streaming 256-bit words into a PCIe-side FIFO.

module ddr3_read_master (
  input  logic         sys_clk,
  input  logic         sys_nrst,
  input  logic         rd_start,
  input  logic [24:0]  rd_base_addr,
  input  logic [24:0]  rd_length,
  output logic         ddr3_rd_req,
  output logic [24:0]  ddr3_rd_addr,
  input  logic         ddr3_rd_ack,
  input  logic [255:0] ddr3_rd_data,
  input  logic         ddr3_rd_valid,
  input  logic         fifo_prog_full,
  output logic         fifo_wr_en,
  output logic [255:0] fifo_din,
  output logic         busy,
  output logic         done,
  output logic         rd_err
);

  localparam logic [24:0] ADDR_MAX = 25'd32799999;
  localparam logic [3:0]  OUT_MAX  = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [24:0]    addr_q, addr_d;
  logic [24:0]    rem_q, rem_d;
  logic [3:0]     outst_q, outst_d;
  logic           req_q, req_d;
  logic           wr_en_q, wr_en_d;
  logic [255:0]   din_q, din_d;
  logic           err_q, err_d;
  logic           acked;
  logic           accept;

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      outst_q <= '0;
      req_q   <= 1'b0;
      wr_en_q <= 1'b0;
      din_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      outst_q <= outst_d;
      req_q   <= req_d;
      wr_en_q <= wr_en_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end

  // next-state, request issue and read-data forwarding
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    outst_d = outst_q;
    req_d   = req_q;
    din_d   = din_q;
    err_d   = err_q;
    acked   = req_q & ddr3_rd_ack;
    accept  = ddr3_rd_valid & (outst_q != 4'd0);
    wr_en_d = accept;

    if (accept) begin
      din_d = ddr3_rd_data;
    end
    if (ddr3_rd_valid && !accept) begin
      err_d = 1'b1;
    end

    if (acked && !accept) begin
      outst_d = outst_q + 4'd1;
    end else if (!acked && accept) begin
      outst_d = outst_q - 4'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (rd_start) begin
          if (rd_length != 25'd0) begin
            addr_d  = (rd_base_addr > ADDR_MAX) ? 25'd0
                                                : rd_base_addr;
            rem_d   = rd_length;
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        if (acked) begin
          req_d  = 1'b0;
          addr_d = (addr_q == ADDR_MAX) ? 25'd0
                                        : addr_q + 25'd1;
          rem_d  = rem_q - 25'd1;
          if (rem_q == 25'd1) begin
            state_d = DRAIN;
          end
        end else if (!req_q && rem_q != 25'd0 &&
                     outst_q < OUT_MAX && !fifo_prog_full) begin
          req_d = 1'b1;
        end
      end
      DRAIN: begin
        if (outst_q == 4'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ddr3_rd_req  = req_q;
  assign ddr3_rd_addr = addr_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_din     = din_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign rd_err       = err_q;

endmodule

// File: tb/tb_ddr3_read_master.sv
// tb_ddr3_read_master: vector table for cycle-exact behaviour plus
// DDR3 responder sequences for multi-cycle corner cases.

module tb_ddr3_read_master;

  localparam logic [24:0] AMAX = 25'd32799999;

  logic         sys_clk;
  logic         sys_nrst;
  logic         rd_start;
  logic [24:0]  rd_base_addr;
  logic [24:0]  rd_length;
  logic         ddr3_rd_req;
  logic [24:0]  ddr3_rd_addr;
  logic         ddr3_rd_ack;
  logic [255:0] ddr3_rd_data;
  logic         ddr3_rd_valid;
  logic         fifo_prog_full;
  logic         fifo_wr_en;
  logic [255:0] fifo_din;
  logic         busy;
  logic         done;
  logic         rd_err;

  ddr3_read_master dut (
    .sys_clk        (sys_clk),
    .sys_nrst       (sys_nrst),
    .rd_start       (rd_start),
    .rd_base_addr   (rd_base_addr),
    .rd_length      (rd_length),
    .ddr3_rd_req    (ddr3_rd_req),
    .ddr3_rd_addr   (ddr3_rd_addr),
    .ddr3_rd_ack    (ddr3_rd_ack),
    .ddr3_rd_data   (ddr3_rd_data),
    .ddr3_rd_valid  (ddr3_rd_valid),
    .fifo_prog_full (fifo_prog_full),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_din       (fifo_din),
    .busy           (busy),
    .done           (done),
    .rd_err         (rd_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic         st;
    logic [24:0]  base;
    logic [24:0]  len;
    logic         ack;
    logic         vld;
    logic [255:0] dat;
    logic         pf;
    logic         e_req;
    logic [24:0]  e_addr;
    logic         e_wr;
    logic [255:0] e_din;
    logic         e_busy;
    logic         e_done;
    logic         e_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic st, logic [24:0] base, logic [24:0] len,
    logic ack, logic vld, logic [255:0] dat, logic pf,
    logic e_req, logic [24:0] e_addr, logic e_wr,
    logic [255:0] e_din, logic e_busy, logic e_done,
    logic e_err);
    vec_t v;
    v.st = st; v.base = base; v.len = len;
    v.ack = ack; v.vld = vld; v.dat = dat; v.pf = pf;
    v.e_req = e_req; v.e_addr = e_addr; v.e_wr = e_wr;
    v.e_din = e_din; v.e_busy = e_busy;
    v.e_done = e_done; v.e_err = e_err;
    return v;
  endfunction

  function automatic logic [255:0] mkdata(logic [24:0] a);
    return {8{7'd0, a}};
  endfunction

  function automatic logic [24:0] nxt(logic [24:0] a);
    return (a == AMAX) ? 25'd0 : a + 25'd1;
  endfunction

  // responder / scoreboard state
  int          cyc;
  int          ack_lat;
  bit          valid_en;
  bit          pf;
  int          req_age;
  int          due_q[$];
  logic [24:0] vaddr_q[$];
  logic [24:0] wr_exp_q[$];
  logic [24:0] alog[$];
  logic [24:0] exp_addr;
  int          n_ack, n_wr, n_done, n_vld;
  int          viol, pf_rise;
  logic        req_prev;
  logic        st_pend;
  logic [24:0] st_base, st_len;

  task automatic clr();
    n_ack = 0; n_wr = 0; n_done = 0; n_vld = 0;
    viol = 0; pf_rise = 0; req_age = 0;
    req_prev = 1'b0;
    due_q.delete(); vaddr_q.delete();
    wr_exp_q.delete(); alog.delete();
  endtask

  task automatic start(logic [24:0] b, logic [24:0] l);
    exp_addr = (b > AMAX) ? 25'd0 : b;
    st_pend = 1'b1; st_base = b; st_len = l;
  endtask

  task automatic step();
    logic [24:0] a;
    bit gave;
    @(negedge sys_clk);
    rd_start = st_pend;
    rd_base_addr = st_base;
    rd_length = st_len;
    st_pend = 1'b0;
    fifo_prog_full = pf;
    ddr3_rd_ack = 1'b0;
    ddr3_rd_valid = 1'b0;
    ddr3_rd_data = '0;
    if (ddr3_rd_req) begin
      req_age++;
      if (req_age >= ack_lat) begin
        ddr3_rd_ack = 1'b1;
        req_age = 0;
        chk("ack_addr", 256'(ddr3_rd_addr), 256'(exp_addr));
        alog.push_back(ddr3_rd_addr);
        due_q.push_back(cyc + 5);
        vaddr_q.push_back(ddr3_rd_addr);
        exp_addr = nxt(exp_addr);
        n_ack++;
      end
    end else begin
      req_age = 0;
    end
    gave = 1'b0;
    if (valid_en && due_q.size() != 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      a = vaddr_q.pop_front();
      ddr3_rd_valid = 1'b1;
      ddr3_rd_data = mkdata(a);
      wr_exp_q.push_back(a);
      gave = 1'b1;
      n_vld++;
    end
    @(posedge sys_clk);
    #1;
    cyc++;
    chk("wr_en_lat", 256'(fifo_wr_en), 256'(gave));
    if (gave) begin
      a = wr_exp_q.pop_front();
      if (fifo_wr_en === 1'b1) chk("fifo_din", fifo_din, mkdata(a));
    end
    if (fifo_wr_en === 1'b1) n_wr++;
    if (done === 1'b1) n_done++;
    if (n_ack - n_vld >= 8 && ddr3_rd_req === 1'b1) viol++;
    if (n_ack - n_vld > 8) viol++;
    if (fifo_prog_full && ddr3_rd_req && !req_prev) pf_rise++;
    req_prev = ddr3_rd_req;
  endtask

  task automatic run_until_done(string nm, int bound);
    int k;
    k = 0;
    while (n_done == 0 && k < bound) begin
      step();
      k++;
    end
    chk({nm, "_timeout"}, 256'(n_done != 0), 256'(1));
    repeat (3) step();
  endtask

  vec_t tv[$];
  logic [255:0] DA, DB, DC, DD;

  initial begin
    DA = {8{32'hAAAA0001}};
    DB = {8{32'hBBBB0002}};
    DC = {8{32'hCCCC0003}};
    DD = {8{32'hDDDD0004}};
    // st base len ack vld dat pf | req addr wr din busy done err
    tv.push_back(mk(1, 5, 2, 0, 0, 0, 0,   0, 5, 0, 0, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   1, 5, 0, 0, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 0, 0, 0,   0, 6, 0, 0, 1, 0, 0));
    tv.push_back(mk(1, 50, 7, 0, 0, 0, 0,  1, 6, 0, 0, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, DA, 0,  0, 7, 1, DA, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 7, 0, DA, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, DB, 0,  0, 7, 1, DB, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 7, 0, DB, 1, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 7, 0, DB, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, DC, 0,  0, 7, 0, DB, 0, 0, 1));
    tv.push_back(mk(1, 9, 0, 0, 0, 0, 0,   0, 7, 0, DB, 1, 1, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 7, 0, DB, 0, 0, 1));
    tv.push_back(mk(1, 25'h1FFFFFF, 1, 0, 0, 0, 0,
                    0, 0, 0, DB, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, DB, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, DB, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 0, 0, 0,   0, 1, 0, DB, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, DD, 0,  0, 1, 1, DD, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, DD, 1, 1, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, DD, 0, 0, 1));

    sys_nrst = 1'b0;
    rd_start = 1'b0; rd_base_addr = '0; rd_length = '0;
    ddr3_rd_ack = 1'b0; ddr3_rd_valid = 1'b0;
    ddr3_rd_data = '0; fifo_prog_full = 1'b0;
    cyc = 0; ack_lat = 2; valid_en = 1'b1; pf = 1'b0;
    st_pend = 1'b0; st_base = '0; st_len = '0;
    exp_addr = '0;
    clr();

    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_req", 256'(ddr3_rd_req), 0);
    chk("rst_addr", 256'(ddr3_rd_addr), 0);
    chk("rst_wr", 256'(fifo_wr_en), 0);
    chk("rst_din", fifo_din, 0);
    chk("rst_busy", 256'(busy), 0);
    chk("rst_done", 256'(done), 0);
    chk("rst_err", 256'(rd_err), 0);
    @(negedge sys_clk);
    sys_nrst = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge sys_clk);
      rd_start = tv[i].st;
      rd_base_addr = tv[i].base;
      rd_length = tv[i].len;
      ddr3_rd_ack = tv[i].ack;
      ddr3_rd_valid = tv[i].vld;
      ddr3_rd_data = tv[i].dat;
      fifo_prog_full = tv[i].pf;
      @(posedge sys_clk);
      #1;
      chk($sformatf("v%0d_req", i), 256'(ddr3_rd_req),
          256'(tv[i].e_req));
      chk($sformatf("v%0d_addr", i), 256'(ddr3_rd_addr),
          256'(tv[i].e_addr));
      chk($sformatf("v%0d_wr", i), 256'(fifo_wr_en),
          256'(tv[i].e_wr));
      chk($sformatf("v%0d_din", i), fifo_din, tv[i].e_din);
      chk($sformatf("v%0d_busy", i), 256'(busy),
          256'(tv[i].e_busy));
      chk($sformatf("v%0d_done", i), 256'(done),
          256'(tv[i].e_done));
      chk($sformatf("v%0d_err", i), 256'(rd_err),
          256'(tv[i].e_err));
    end

    // base 100, length 4
    clr();
    start(25'd100, 25'd4);
    run_until_done("a", 200);
    chk("a_acks", 256'(n_ack), 4);
    chk("a_writes", 256'(n_wr), 4);
    chk("a_done", 256'(n_done), 1);
    chk("a_busy", 256'(busy), 0);
    chk("a_viol", 256'(viol), 0);

    // address wrap at the top of the range
    clr();
    start(25'd32799998, 25'd3);
    run_until_done("b", 200);
    chk("b_acks", 256'(alog.size()), 3);
    if (alog.size() == 3) begin
      chk("b_addr0", 256'(alog[0]), 256'(25'd32799998));
      chk("b_addr1", 256'(alog[1]), 256'(25'd32799999));
      chk("b_addr2", 256'(alog[2]), 0);
    end
    chk("b_writes", 256'(n_wr), 3);

    // valid withheld: outstanding limit of 8
    clr();
    valid_en = 1'b0;
    start(25'd200, 25'd20);
    repeat (60) step();
    chk("c_acks_held", 256'(n_ack), 8);
    chk("c_req_low", 256'(ddr3_rd_req), 0);
    chk("c_busy", 256'(busy), 1);
    chk("c_no_wr", 256'(n_wr), 0);
    valid_en = 1'b1;
    run_until_done("c", 600);
    chk("c_acks", 256'(n_ack), 20);
    chk("c_writes", 256'(n_wr), 20);
    chk("c_viol", 256'(viol), 0);

    // prog_full while a request is pending
    clr();
    ack_lat = 4;
    start(25'd300, 25'd3);
    begin
      int k;
      k = 0;
      while (ddr3_rd_req !== 1'b1 && k < 20) begin
        step();
        k++;
      end
    end
    chk("d_req_seen", 256'(ddr3_rd_req), 1);
    pf = 1'b1;
    repeat (12) step();
    chk("d_acks_pf", 256'(n_ack), 1);
    chk("d_req_low", 256'(ddr3_rd_req), 0);
    chk("d_pf_rise", 256'(pf_rise), 0);
    pf = 1'b0;
    run_until_done("d", 200);
    chk("d_acks", 256'(n_ack), 3);
    chk("d_writes", 256'(n_wr), 3);
    ack_lat = 2;

    // reset mid-transfer, stray data, then a clean transfer
    clr();
    start(25'd400, 25'd10);
    repeat (12) step();
    chk("e_busy_pre", 256'(busy), 1);
    #2;
    sys_nrst = 1'b0;
    #1;
    chk("e_rst_req", 256'(ddr3_rd_req), 0);
    chk("e_rst_addr", 256'(ddr3_rd_addr), 0);
    chk("e_rst_wr", 256'(fifo_wr_en), 0);
    chk("e_rst_din", fifo_din, 0);
    chk("e_rst_busy", 256'(busy), 0);
    chk("e_rst_done", 256'(done), 0);
    chk("e_rst_err", 256'(rd_err), 0);
    repeat (2) @(negedge sys_clk);
    ddr3_rd_ack = 1'b0;
    ddr3_rd_valid = 1'b0;
    sys_nrst = 1'b1;
    @(negedge sys_clk);
    ddr3_rd_valid = 1'b1;
    ddr3_rd_data = DC;
    @(posedge sys_clk);
    #1;
    chk("e_stray_wr", 256'(fifo_wr_en), 0);
    chk("e_stray_err", 256'(rd_err), 1);
    chk("e_stray_busy", 256'(busy), 0);
    clr();
    start(25'd7, 25'd2);
    run_until_done("e", 200);
    chk("e_acks", 256'(n_ack), 2);
    chk("e_writes", 256'(n_wr), 2);
    chk("e_done", 256'(n_done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
